// File: rtl/weight_loader.sv
// Write controller that streams 16-bit beats into the eight 1-bit weight SRAM
// lanes and then into the BN-parameter SRAM, finishing with a one-cycle done pulse.
module weight_loader #(
   parameter int weight_width  = 1,
   parameter int addr_width    = 9,
   parameter int bn_addr_width = 7,
   parameter int bn_width      = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [addr_width:0]         n_w,
   input  logic [bn_addr_width:0]      n_bn,
   input  logic [7:0]                  lane_mask,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [bn_width-1:0]         s_data,
   output logic [7:0]                  w_cs,
   output logic [7:0]                  w_we,
   output logic                        w_oe,
   output logic [addr_width-1:0]       w_addr,
   output logic [8*weight_width-1:0]   w_data,
   output logic                        bn_cs,
   output logic                        bn_we,
   output logic                        bn_oe,
   output logic [bn_addr_width-1:0]    bn_addr,
   output logic [bn_width-1:0]         bn_data,
   output logic                        busy,
   output logic                        done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD_W  = 2'd1,
      LOAD_BN = 2'd2,
      FINISH  = 2'd3
   } state_t;

   localparam logic [addr_width:0]    w_max  = {1'b1, {addr_width{1'b0}}};
   localparam logic [addr_width:0]    w_one  = {{addr_width{1'b0}}, 1'b1};
   localparam logic [bn_addr_width:0] bn_max = {1'b1, {bn_addr_width{1'b0}}};
   localparam logic [bn_addr_width:0] bn_one = {{bn_addr_width{1'b0}}, 1'b1};

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [addr_width:0]     n_w_r;
   logic [bn_addr_width:0]  n_bn_r;
   logic [7:0]              mask_r;
   logic [addr_width:0]     w_cnt_r;
   logic [bn_addr_width:0]  bn_cnt_r;
   logic [addr_width:0]     n_w_cl_s;
   logic [bn_addr_width:0]  n_bn_cl_s;
   logic                    w_last_s;
   logic                    bn_last_s;

   function automatic logic [addr_width:0] clamp_w(input logic [addr_width:0] v);
      if (v > w_max) begin
         clamp_w = w_max;
      end else begin
         clamp_w = v;
      end
   endfunction

   function automatic logic [bn_addr_width:0] clamp_bn(input logic [bn_addr_width:0] v);
      if (v > bn_max) begin
         clamp_bn = bn_max;
      end else begin
         clamp_bn = v;
      end
   endfunction

   assign n_w_cl_s  = clamp_w(n_w);
   assign n_bn_cl_s = clamp_bn(n_bn);
   assign w_last_s  = (w_cnt_r == (n_w_r - w_one));
   assign bn_last_s = (bn_cnt_r == (n_bn_r - bn_one));

   // The loader never reads, so both output enables stay low to avoid bus contention.
   assign w_oe    = 1'b0;
   assign bn_oe   = 1'b0;
   assign s_ready = (state_r == LOAD_W) || (state_r == LOAD_BN);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state selection; zero counts skip their phase entirely.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (n_w_cl_s != {(addr_width+1){1'b0}}) begin
                  state_nxt_s = LOAD_W;
               end else if (n_bn_cl_s != {(bn_addr_width+1){1'b0}}) begin
                  state_nxt_s = LOAD_BN;
               end else begin
                  state_nxt_s = FINISH;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LOAD_W: begin
            if (s_valid && w_last_s) begin
               if (n_bn_r != {(bn_addr_width+1){1'b0}}) begin
                  state_nxt_s = LOAD_BN;
               end else begin
                  state_nxt_s = FINISH;
               end
            end else begin
               state_nxt_s = LOAD_W;
            end
         end
         LOAD_BN: begin
            if (s_valid && bn_last_s) begin
               state_nxt_s = FINISH;
            end else begin
               state_nxt_s = LOAD_BN;
            end
         end
         FINISH: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Command capture, beat counters and registered SRAM write cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_w_r    <= {(addr_width+1){1'b0}};
         n_bn_r   <= {(bn_addr_width+1){1'b0}};
         mask_r   <= 8'h00;
         w_cnt_r  <= {(addr_width+1){1'b0}};
         bn_cnt_r <= {(bn_addr_width+1){1'b0}};
         w_cs     <= 8'h00;
         w_we     <= 8'h00;
         w_addr   <= {addr_width{1'b0}};
         w_data   <= {(8*weight_width){1'b0}};
         bn_cs    <= 1'b0;
         bn_we    <= 1'b0;
         bn_addr  <= {bn_addr_width{1'b0}};
         bn_data  <= {bn_width{1'b0}};
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         // Strobes are single-cycle; address and data hold between writes.
         w_cs  <= 8'h00;
         w_we  <= 8'h00;
         bn_cs <= 1'b0;
         bn_we <= 1'b0;
         done  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  n_w_r    <= n_w_cl_s;
                  n_bn_r   <= n_bn_cl_s;
                  mask_r   <= lane_mask;
                  w_cnt_r  <= {(addr_width+1){1'b0}};
                  bn_cnt_r <= {(bn_addr_width+1){1'b0}};
                  busy     <= 1'b1;
               end
            end
            LOAD_W: begin
               if (s_valid) begin
                  w_cs    <= mask_r;
                  w_we    <= mask_r;
                  w_addr  <= w_cnt_r[addr_width-1:0];
                  w_data  <= s_data[8*weight_width-1:0];
                  w_cnt_r <= w_cnt_r + w_one;
               end
            end
            LOAD_BN: begin
               if (s_valid) begin
                  bn_cs    <= 1'b1;
                  bn_we    <= 1'b1;
                  bn_addr  <= bn_cnt_r[bn_addr_width-1:0];
                  bn_data  <= s_data;
                  bn_cnt_r <= bn_cnt_r + bn_one;
               end
            end
            FINISH: begin
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Upstream write controller for the 8-lane binary weight SRAM bank and its BN-parameter SRAM.
- Accepts a valid/ready stream of 16-bit beats after a start command.
- Beats are written first into the eight 1-bit weight lanes, then into the 16-bit BN memory.
- Generates registered cs/we/oe/addr/data for the bank, then reports completion with a done pulse.

Parameters:
- weight_width, 1, bits per weight lane word (fixed at 1; lane data is one bit of the beat)
- addr_width, 9, weight SRAM address width (512 entries per lane)
- bn_addr_width, 7, BN SRAM address width (128 entries)
- bn_width, 16, BN word width, equal to the stream beat width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle load request, sampled only in IDLE
- n_w  in  addr_width+1  weight beats to load, 0..512, captured at start
- n_bn  in  bn_addr_width+1  BN beats to load, 0..128, captured at start
- lane_mask  in  8  lanes enabled for weight writes, captured at start
- s_valid  in  1  stream beat valid
- s_ready  out  1  stream beat accepted when s_valid & s_ready
- s_data  in  bn_width  stream beat
- w_cs  out  8  per-lane chip select, active high
- w_we  out  8  per-lane write enable, active high
- w_oe  out  1  weight lane output enable, held 0 (loader never reads)
- w_addr  out  addr_width  shared address for all eight lanes
- w_data  out  8  bit i drives lane i data
- bn_cs  out  1  BN chip select, active high
- bn_we  out  1  BN write enable, active high
- bn_oe  out  1  BN output enable, held 0
- bn_addr  out  bn_addr_width  BN address
- bn_data  out  bn_width  BN write data
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse at load completion

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0. Reset is asynchronous and may occur at any time, including mid-load; the load is abandoned and no partial-state write is emitted after reset.
- FSM states: IDLE, LOAD_W, LOAD_BN, FINISH.
- IDLE + start:
  - Capture n_w, n_bn and lane_mask, then set busy=1.
  - Next state is LOAD_W if n_w != 0, else LOAD_BN if n_bn != 0, else FINISH.
- start while busy is ignored, with no effect on counters or captured values.
- s_ready is 1 only in LOAD_W and LOAD_BN; it is combinational from the state.
- LOAD_W, on an accepted beat:
  - Next cycle: w_cs = w_we = lane_mask, w_addr = w_cnt, w_data = s_data[7:0].
  - w_cnt increments.
  - When w_cnt reaches n_w-1 on acceptance, go to LOAD_BN if n_bn != 0, else FINISH.
  - s_data[15:8] is ignored in this state.
- LOAD_BN, on an accepted beat:
  - Next cycle: bn_cs = bn_we = 1, bn_addr = bn_cnt, bn_data = s_data.
  - bn_cnt increments.
  - Go to FINISH on the last beat.
- Write strobes are one cycle wide. With no accepted beat, all cs/we outputs are 0 and addr/data hold their last values.
- Latency: beat accepted at edge k produces a write cycle between edges k and k+1. The SRAM captures it at edge k+1.
- Back-to-back beats give back-to-back writes at consecutive addresses.
- s_valid gaps insert idle cycles with cs/we=0; no write is dropped or duplicated.
- FINISH lasts exactly one cycle:
  - It begins after the final write cycle has been presented, so done never precedes the final write strobe.
  - done=1 and busy=0 are registered on the transition to IDLE.
  - The final write strobe and done can never coincide.
- Counter wrap:
  - n_w=512 gives addresses 0..511. The counter is addr_width+1 wide, so there is no wrap before termination.
  - n_bn=128 gives BN addresses 0..127.
- Out-of-range counts (n_w>512, n_bn>128) are clamped to the maximum at capture.
- lane_mask=0: weight beats are still consumed and counted, but no w_cs/w_we is asserted.
- w_oe and bn_oe are constant 0 in every state, so the loader and the bank never contend on the data bus.

Test Plan:
- Reset, then start with n_w=4, n_bn=2, lane_mask=FF; stream beats 0x0001, 0x0002, 0x0004, 0x0080, 0xBEEF, 0x1234 with s_valid held 1.
  - Expect w_addr 0..3 with w_data 01, 02, 04, 80 on consecutive cycles.
  - Then bn_addr 0, 1 with bn_data BEEF, 1234.
  - Then a single done pulse; busy covers the whole load.
- n_w=512, n_bn=128, random s_valid gaps (about 30%): exactly 512 weight and 128 BN write strobes, last addresses 511 and 127, no duplicate addresses; a shadow memory matches the stream.
- start with n_w=0, n_bn=0: no s_ready and no cs/we at any time; done pulses 2 cycles after start.
- lane_mask=0x05, n_w=3: w_cs/w_we = 05 on each write; all 3 beats are consumed.
- Assert start again during LOAD_W: it is ignored and the counts are unchanged. Pull rst_n low after 5 weight beats: outputs go to 0 asynchronously; after release, the FSM is IDLE with no further strobes.
